// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC datapath stages.
// Fixed-point results are signed Q1.15; accumulation is done wider and narrowed at the end.
package mac_pkg;

    typedef logic signed [15:0] q1_15_t;

    localparam q1_15_t Q15_MAX = 16'sh7FFF;
    localparam q1_15_t Q15_MIN = 16'sh8000;

    localparam int MAC_PWIDTH    = 16;
    localparam int MAC_MAX_TERMS = 8;
    localparam int MAC_OWIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/mac_accum_sat_q15.sv
// Combinational narrowing saturator: clamps a wide signed value into OWIDTH bits
// and flags when clamping happened. Requires IWIDTH > OWIDTH.
module sat_q15 #(
    parameter int IWIDTH = 19,
    parameter int OWIDTH = 16
) (
    input  logic signed [IWIDTH-1:0] in_value,
    output logic signed [OWIDTH-1:0] out_value,
    output logic                     overflow
);

    localparam int XBITS = IWIDTH - OWIDTH;

    // A value fits when every bit above the output sign bit repeats the input sign.
    logic [XBITS-1:0] agree;

    genvar gi;
    generate
        for (gi = 0; gi < XBITS; gi++) begin : g_agree
            assign agree[gi] = (in_value[OWIDTH-1+gi] == in_value[IWIDTH-1]);
        end
    endgenerate

    always_comb begin
        overflow  = ~(&agree);
        out_value = in_value[OWIDTH-1:0];
        if (overflow) begin
            out_value = in_value[IWIDTH-1] ? {1'b1, {(OWIDTH-1){1'b0}}}
                                           : {1'b0, {(OWIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_accum.sv
// Accumulate stage of the MAC datapath: sums signed Q1.15 products of one vector
// in a guarded accumulator and presents the saturated Q1.15 result on valid/ready.
module mac_accum
    import mac_pkg::*;
#(
    parameter int PWIDTH    = MAC_PWIDTH,
    parameter int MAX_TERMS = MAC_MAX_TERMS,
    parameter int GUARD     = $clog2(MAX_TERMS),
    parameter int AWIDTH    = PWIDTH + GUARD,
    parameter int OWIDTH    = MAC_OWIDTH,
    parameter int CWIDTH    = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PWIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OWIDTH-1:0] out_data,
    output logic              out_sat,
    output logic [CWIDTH-1:0] out_count
);

    mac_state_t               state_reg;
    logic signed [AWIDTH-1:0] acc_reg;
    logic [CWIDTH-1:0]        count_reg;
    logic                     in_ready_reg;
    logic                     out_valid_reg;
    logic [OWIDTH-1:0]        out_data_reg;
    logic                     out_sat_reg;
    logic [CWIDTH-1:0]        out_count_reg;

    logic signed [AWIDTH-1:0] acc_base;
    logic signed [AWIDTH-1:0] sum_next;
    logic [CWIDTH-1:0]        count_next;
    logic                     accept;
    logic                     is_final;
    logic signed [OWIDTH-1:0] sat_value;
    logic                     sat_flag;

    // IDLE ignores the held accumulator so every vector starts from zero.
    assign acc_base   = (state_reg == IDLE) ? '0 : acc_reg;
    assign sum_next   = acc_base + AWIDTH'($signed(in_data));
    assign count_next = count_reg + CWIDTH'(1);
    assign accept     = in_valid && in_ready_reg;
    assign is_final   = in_last || (count_next == CWIDTH'(MAX_TERMS));

    sat_q15 #(
        .IWIDTH (AWIDTH),
        .OWIDTH (OWIDTH)
    ) u_sat (
        .in_value  (sum_next),
        .out_value (sat_value),
        .overflow  (sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            out_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (is_final) begin
                            out_data_reg  <= sat_value;
                            out_sat_reg   <= sat_flag;
                            out_count_reg <= count_next;
                            out_valid_reg <= 1'b1;
                            in_ready_reg  <= 1'b0;
                            acc_reg       <= '0;
                            count_reg     <= '0;
                            state_reg     <= HOLD;
                        end else begin
                            acc_reg   <= sum_next;
                            count_reg <= count_next;
                            state_reg <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Result fields stay put until consumed; only out_valid drops.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;
    assign out_count = out_count_reg;

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: directed vectors followed by random vectors,
// each compared against an integer-arithmetic model of the vector sum.
module tb_mac_accum;
    import mac_pkg::*;

    localparam int MAXT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic [3:0]  out_count;

    int checks = 0;
    int errors = 0;

    int          model_sum = 0;
    int          model_cnt = 0;
    logic [15:0] exp_data  = '0;
    logic        exp_sat   = 1'b0;
    int          exp_count = 0;
    int          vec_id    = 0;

    mac_accum dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] clamp_q15(input int s);
        if (s > 32767)       return Q15_MAX;
        else if (s < -32768) return Q15_MIN;
        else                 return 16'(s);
    endfunction

    function automatic logic out_of_range(input int s);
        return (s > 32767) || (s < -32768);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic beat(input logic [15:0] d, input logic l, output bit fin);
        check("in_ready_before_beat", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        model_sum += int'($signed(d));
        model_cnt++;
        fin = l || (model_cnt == MAXT);
        if (fin) begin
            exp_data  = clamp_q15(model_sum);
            exp_sat   = out_of_range(model_sum);
            exp_count = model_cnt;
            model_sum = 0;
            model_cnt = 0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'($urandom);
        check("out_valid_after_beat", 32'(out_valid), 32'(fin));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("no_output_in_gap", 32'(out_valid), 32'(0));
        end
    endtask

    task automatic check_held();
        check("out_valid_hold", 32'(out_valid), 32'(1));
        check("out_data",       32'(out_data),  32'(exp_data));
        check("out_sat",        32'(out_sat),   32'(exp_sat));
        check("out_count",      32'(out_count), 32'(exp_count));
        check("in_ready_hold",  32'(in_ready),  32'(0));
    endtask

    // Checks the presented result, stalls for a while, then consumes it.
    task automatic take_result(input int stall, input bit poke);
        out_ready = 1'b0;
        check_held();
        repeat (stall) begin
            in_valid = poke;
            in_data  = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_held();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop",     32'(out_valid), 32'(0));
        check("in_ready_return",    32'(in_ready),  32'(1));
        check("out_data_persists",  32'(out_data),  32'(exp_data));
        $display("vec %0d: data=%04h sat=%0d count=%0d stall=%0d",
                 vec_id, out_data, out_sat, out_count, stall);
        vec_id++;
    endtask

    initial begin
        bit fin;
        int len;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        check("rst_out_sat",   32'(out_sat),   32'(0));
        check("rst_out_count", 32'(out_count), 32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));

        // Three quarter-scale terms.
        beat(16'h2000, 1'b0, fin);
        beat(16'h2000, 1'b0, fin);
        beat(16'h2000, 1'b1, fin);
        take_result(0, 1'b0);

        // Positive and negative saturation, then a cancelling pair.
        beat(16'h7000, 1'b0, fin);
        beat(16'h7000, 1'b1, fin);
        take_result(0, 1'b0);
        beat(16'h8000, 1'b0, fin);
        beat(16'h8000, 1'b1, fin);
        take_result(0, 1'b0);
        beat(16'h7000, 1'b0, fin);
        beat(16'h9000, 1'b1, fin);
        take_result(0, 1'b0);

        // Forced end on the eighth term, then a fresh single-term vector.
        for (int i = 0; i < MAXT; i++) beat(16'h0100, 1'b0, fin);
        take_result(0, 1'b0);
        beat(16'h0100, 1'b1, fin);
        take_result(0, 1'b0);

        // Backpressure with in_valid held high.
        beat(16'h1234, 1'b0, fin);
        beat(16'h1111, 1'b1, fin);
        take_result(5, 1'b1);

        // Reset in the middle of a vector discards the partial sum.
        beat(16'h4000, 1'b0, fin);
        beat(16'h4000, 1'b0, fin);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_sum = 0;
        model_cnt = 0;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_in_ready",  32'(in_ready),  32'(1));
        beat(16'h1000, 1'b1, fin);
        take_result(0, 1'b0);

        // Gaps inside a vector.
        beat(16'h0010, 1'b0, fin);
        idle(3);
        beat(16'hFFF0, 1'b1, fin);
        take_result(0, 1'b0);

        // Random vectors: lengths up to one beyond the forced limit, random gaps and stalls.
        for (int v = 0; v < 40; v++) begin
            len = $urandom_range(1, MAXT + 1);
            for (int i = 0; i < len; i++) begin
                beat(16'($urandom), (i == len - 1), fin);
                if (fin) break;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            take_result($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_accum.md
Name: mac_accum

Overview:
Downstream accumulate stage of the MAC datapath. It consumes the stream of signed Q1.15 products from the multiplier and sums the terms of one dot-product vector in a widened accumulator. At vector end it saturates the sum to Q1.15 and presents it on a valid/ready output. It supplies the "accumulate" half of MAC, paired with the combinational multiplier upstream.

Parameters:
PWIDTH, 16, product input width; signed Q1.15.
MAX_TERMS, 8, maximum terms per vector; the accumulator forces vector end on the MAX_TERMS-th accepted beat.
GUARD, $clog2(MAX_TERMS), accumulator guard bits.
AWIDTH, PWIDTH+GUARD, internal accumulator width; signed Q(1+GUARD).15.
OWIDTH, 16, result width; signed Q1.15.
CWIDTH, $clog2(MAX_TERMS+1), term counter width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  product beat valid
in_ready  out  1  accumulator can accept a beat
in_data  in  PWIDTH  signed Q1.15 product
in_last  in  1  beat is the final term of the vector
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  OWIDTH  saturated signed Q1.15 sum
out_sat  out  1  saturation occurred on this result
out_count  out  CWIDTH  number of terms summed into this result

Behaviour:
- Reset (rst=1 at a clock edge, any state): state=IDLE, acc=0, count=0, out_valid=0, out_data=0, out_sat=0, out_count=0. A partial vector is discarded. in_ready=1 from the first cycle after reset.
- States: IDLE (no terms yet), ACCUM (at least 1 term held), HOLD (result presented).
- in_ready is 1 in IDLE and ACCUM and 0 in HOLD. A beat is accepted when in_valid && in_ready.
- Term add: sum = acc + sign_extend(in_data, AWIDTH). In IDLE, acc is treated as 0 so a new vector starts clean. in_data=0x8000 is taken as -1.0 without correction.
- A beat is final when in_last=1, or when count+1 == MAX_TERMS.
- Non-final accepted beat: acc<=sum, count<=count+1, state<=ACCUM.
- Final accepted beat:
  - out_data<=sat(sum), out_sat<=(sum out of range), out_count<=count+1.
  - out_valid<=1, state<=HOLD, acc<=0, count<=0.
- Latency: out_valid rises on the clock edge after the final beat is accepted (1 cycle).
- Throughput: 1 term/cycle within a vector. There is at least 1 bubble between vectors because in_ready=0 during HOLD.
- sat(): if sum > 32767, output 0x7FFF. If sum < -32768, output 0x8000. Otherwise output sum[15:0]. Intermediate acc never saturates; GUARD bits guarantee no wrap for MAX_TERMS terms.
- HOLD: out_data, out_sat and out_count are stable while out_valid && !out_ready. On out_valid && out_ready: out_valid<=0, state<=IDLE. in_ready returns to 1 the next cycle.
- No beat arriving in ACCUM means the block waits indefinitely with acc held. in_valid=0 is never an error.
- Single-beat vector (in_last on the first beat in IDLE) gives a result equal to sat(in_data), with out_count=1.
- out_data is not cleared on handshake; only out_valid qualifies it.

Decomposition:
- Package mac_pkg:
  - typedef q1_15_t (logic signed [15:0]).
  - Constants Q15_MAX=16'sh7FFF and Q15_MIN=16'sh8000.
  - Enum mac_state_t {IDLE, ACCUM, HOLD}.
  - Width helper constants PWIDTH, MAX_TERMS and OWIDTH defaults.
- One sub-module, sat_q15: combinational AWIDTH→OWIDTH saturator that outputs the value and an overflow flag. It is reusable by later rounding/output stages.

Test Plan:
1. Beats 0x2000, 0x2000, 0x2000 (last on the third) with out_ready=1 → 1 cycle after the third beat: out_valid=1, out_data=0x6000, out_sat=0, out_count=3.
2. Beats 0x7000, 0x7000 (last) → out_data=0x7FFF, out_sat=1. Beats 0x8000, 0x8000 (last) → out_data=0x8000, out_sat=1. Beats 0x7000, 0x9000 (last) → out_data=0x0000, out_sat=0.
3. MAX_TERMS=8, eight beats of 0x0100 with in_last=0 → result after the 8th beat: out_data=0x0800, out_count=8. The next beat starts a fresh vector.
4. Backpressure: complete a vector, hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and out_data/out_sat/out_count unchanged throughout. On out_ready=1, out_valid drops the next cycle and in_ready=1.
5. Reset mid-vector: accept 0x4000, 0x4000, assert rst one cycle, then send 0x1000 (last) → out_data=0x1000, out_count=1 (partial sum discarded).
6. in_valid gaps: beats 0x0010, idle 3 cycles, 0xFFF0 (last) → out_data=0x0000, out_count=2, and no output before the last beat.
